lane_reduce_accumulator: RTL and testbench
==========================================

Name: lane_reduce_accumulator

Overview:
- Streaming, parametrised successor to the fixed adder tree plus accumulator pair used by the puzzle solvers.
- Each accepted beat carries NUM_LANES operands with a per-lane enable mask. The block reduces them through a registered binary tree, then accumulates beat sums until an end-of-group flag and emits one group result.
- Input and output use valid/ready handshakes. It sits between a puzzle's per-line parser and the final answer register or BCD display.

Parameters:
- NUM_LANES, 4, operands per beat; must be >= 1.
- W, 8, operand width.
- ACC_W, 32, accumulator/result width; must be >= W + LEVELS.
- CNT_W, 16, beat-counter width.
- SIGNED, 0, 1 = operands, sums and overflow are two's complement; 0 = unsigned.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush: drops in-flight beats, the accumulator and any pending result
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  NUM_LANES*W  lane i at bits [i*W +: W]
- in_mask  in  NUM_LANES  lane i contributes only when in_mask[i]=1, else treated as 0
- in_last  in  1  beat closes the current group
- out_valid  out  1  group result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  ACC_W  group sum (sign-extended lanes when SIGNED)
- out_beats  out  CNT_W  number of beats in the group, including the last beat
- out_overflow  out  1  sticky: accumulation exceeded ACC_W range during this group

Behaviour:
- LEVELS = max(1, ceil(log2(NUM_LANES))). Every tree level is registered. Odd leftover operands pass through a register at their level.
- Each tree level widens by 1 bit. Lanes are extended to ACC_W before the accumulator add (sign-extended if SIGNED, else zero-extended).
- Global advance enable: en = !(out_valid && !out_ready). in_ready = en. While en=0, all pipeline, valid, last, accumulator and counter registers hold.
- Each tree stage carries a valid bit and a last bit. A bubble (valid=0) never modifies the accumulator.
- Latency: a last beat accepted at edge t produces out_valid=1 after edge t+LEVELS+1, assuming no stall. Throughput is 1 beat per cycle.
- Accumulator stage (en=1, final tree stage valid):
  - If the tree output is not last: acc <= base + tree_sum; beats <= base_cnt + 1.
  - If it is last: out_sum <= base + tree_sum; out_beats <= base_cnt + 1; out_valid <= 1; then acc <= 0 and beats <= 0.
  - base is 0 and base_cnt is 0 for the first beat of a group, so back-to-back groups need no idle cycle.
- out_overflow is the sticky OR over the group's adds:
  - unsigned: carry out of ACC_W;
  - signed: operand signs equal and result sign differs.
  - It is cleared together with acc at group end. out_sum wraps modulo 2^ACC_W.
- The beat counter saturates at 2^CNT_W-1.
- Output hold: when out_valid && !out_ready, out_sum, out_beats and out_overflow are stable.
- When out_valid && out_ready and no new result is produced that cycle, out_valid <= 0. A result produced on the same cycle as a handshake replaces the old one, with out_valid staying 1.
- clear=1 takes priority over all data movement: every valid bit, acc, counter and out_valid go to 0; in_ready remains 1.
- Reset (asynchronous, reset_n=0): out_valid=0, out_sum=0, out_beats=0, out_overflow=0, every internal valid bit=0, acc=0. The in_ready output is 1 after reset.
- Reset or clear mid-group discards the partial group. No result is emitted for it.
- in_data, in_mask and in_last are ignored when in_valid=0.
- An all-zero mask still counts as a beat, contributing 0.

Test Plan:
- Single group, NUM_LANES=4, LEVELS=2: in_data lanes {1,2,3,4}, mask 1111, last=1 accepted at edge t -> out_valid after edge t+3, out_sum=10, out_beats=1, out_overflow=0.
- Mask: lanes {10,20,30,40}, mask 0101, last=1 -> out_sum=40. A following beat with mask 0000 and last=1 -> out_sum=0, out_beats=1.
- Back-to-back groups: beats {1,1,1,1}, {2,2,2,2}, {3,3,3,3} with last on the third, immediately followed by {5,5,5,5} with last -> results 24 (beats=3) then 20 (beats=1) on consecutive cycles, with no bubble needed.
- Backpressure: hold out_ready=0 with a result pending -> in_ready=0, out_sum is stable, and in-flight beats are not lost. Raise out_ready -> remaining groups are delivered in order with correct sums.
- Overflow: ACC_W=10, SIGNED=0, two beats of {255,255,255,255}, last on the second -> out_sum=1016 (2040 mod 1024), out_overflow=1. The next group {1,0,0,0} gives overflow=0.
- Signed, and reset mid-group:
  - SIGNED=1, lanes {-1,-1,-1,-1} (8'hFF) -> out_sum=-4 (sign-extended).
  - Send two non-last beats, pulse reset_n low asynchronously mid-cycle -> out_valid=0 immediately. The next group {1,2,3,4} with last -> out_sum=10, out_beats=1.

Source files
------------

// File: rtl/lane_reduce_accumulator_if.sv
// Beat input stream and group result stream of the lane reduce accumulator.
interface lane_reduce_accumulator_if #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned CNT_W     = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [NUM_LANES*W-1:0] in_data;
  logic [NUM_LANES-1:0]   in_mask;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_W-1:0]       out_sum;
  logic [CNT_W-1:0]       out_beats;
  logic                   out_overflow;

  modport master (
    output in_valid, in_data, in_mask, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_beats, out_overflow
  );

  modport slave (
    input  in_valid, in_data, in_mask, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_beats, out_overflow
  );
endinterface

// File: rtl/lane_reduce_accumulator.sv
// Masked lane reduction through a registered binary adder tree, followed by a per-group
// accumulator with beat count and sticky overflow; valid/ready on both sides.
module lane_reduce_accumulator #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned W         = 8,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned CNT_W     = 16,
  parameter bit          SIGNED    = 1'b0
) (
  input logic                     clock,
  input logic                     reset_n,
  input logic                     clear,
  lane_reduce_accumulator_if.slave bus
);

  localparam int unsigned LEVELS = (NUM_LANES <= 1) ? 1 : $clog2(NUM_LANES);
  localparam int unsigned TW     = W + LEVELS;

  function automatic int unsigned lanes_at(int unsigned lvl);
    return (NUM_LANES + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

  logic en;
  logic out_valid_q, out_valid_d;

  // Whole pipeline freezes only while a result is offered and not taken.
  assign en           = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = en;

  // Level 0 registers the masked lanes; level l holds lanes_at(l) operands of W+l bits.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned NO = lanes_at(l);
    localparam int unsigned WO = W + l;

    logic [WO-1:0] sum_q [NO];
    logic [WO-1:0] sum_d [NO];
    logic          vld_q, last_q;
    logic          vld_d, last_d;

    if (l == 0) begin : g_in
      always_comb begin
        for (int j = 0; j < NO; j++) begin
          sum_d[j] = bus.in_mask[j] ? bus.in_data[j*W +: W] : '0;
        end
      end
      assign vld_d  = bus.in_valid;
      assign last_d = bus.in_valid & bus.in_last;
    end else begin : g_add
      localparam int unsigned NI = lanes_at(l - 1);

      always_comb begin
        for (int j = 0; j < NO; j++) begin
          sum_d[j] = {SIGNED & g_lvl[l-1].sum_q[2*j][WO-2], g_lvl[l-1].sum_q[2*j]};
          // Odd leftover operand passes through with only the width extension.
          if (2 * j + 1 < NI) begin
            sum_d[j] = sum_d[j] +
                       {SIGNED & g_lvl[l-1].sum_q[2*j+1][WO-2], g_lvl[l-1].sum_q[2*j+1]};
          end
        end
      end
      assign vld_d  = g_lvl[l-1].vld_q;
      assign last_d = g_lvl[l-1].last_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
        for (int j = 0; j < NO; j++) begin
          sum_q[j] <= '0;
        end
      end else if (clear) begin
        vld_q  <= 1'b0;
        last_q <= 1'b0;
      end else if (en) begin
        vld_q  <= vld_d;
        last_q <= last_d;
        sum_q  <= sum_d;
      end
    end
  end

  logic [TW-1:0]    tree_sum;
  logic [ACC_W-1:0] tree_ext;
  logic             tree_vld, tree_last;

  assign tree_sum  = g_lvl[LEVELS].sum_q[0];
  assign tree_vld  = g_lvl[LEVELS].vld_q;
  assign tree_last = g_lvl[LEVELS].last_q;

  if (ACC_W > TW) begin : g_ext
    assign tree_ext = {{(ACC_W - TW){SIGNED & tree_sum[TW-1]}}, tree_sum};
  end else begin : g_noext
    assign tree_ext = tree_sum;
  end

  logic [ACC_W-1:0] acc_q, acc_d, out_sum_q, out_sum_d, add_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, out_beats_q, out_beats_d;
  logic             ovf_q, ovf_d, out_ovf_q, out_ovf_d;
  logic             add_carry, add_ovf, grp_ovf;

  always_comb begin
    {add_carry, add_sum} = {1'b0, acc_q} + {1'b0, tree_ext};
    if (SIGNED) begin
      add_ovf = (acc_q[ACC_W-1] == tree_ext[ACC_W-1]) && (add_sum[ACC_W-1] != acc_q[ACC_W-1]);
    end else begin
      add_ovf = add_carry;
    end
    grp_ovf = ovf_q | add_ovf;
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (en) begin
      if (out_valid_q) begin
        out_valid_d = 1'b0;
      end
      if (tree_vld) begin
        if (tree_last) begin
          out_sum_d   = add_sum;
          out_beats_d = cnt_inc;
          out_ovf_d   = grp_ovf;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = grp_ovf;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_sum      = out_sum_q;
  assign bus.out_beats    = out_beats_q;
  assign bus.out_overflow = out_ovf_q;

endmodule

// File: tb/tb_lane_reduce_accumulator.sv
// Three lockstep instances (unsigned narrow, signed wide, signed odd-lane) share one stimulus;
// a group-level arithmetic model feeds a scoreboard checked by an independent monitor.
module tb_lane_reduce_accumulator;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_mask = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  int          rdy_mode = 0;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  lane_reduce_accumulator_if #(.NUM_LANES(4), .W(8), .ACC_W(10), .CNT_W(3))  ifa ();
  lane_reduce_accumulator_if #(.NUM_LANES(4), .W(8), .ACC_W(32), .CNT_W(16)) ifb ();
  lane_reduce_accumulator_if #(.NUM_LANES(3), .W(8), .ACC_W(11), .CNT_W(16)) ifc ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.in_mask   = in_mask;
  assign ifa.in_last   = in_last;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.in_mask   = in_mask;
  assign ifb.in_last   = in_last;
  assign ifb.out_ready = out_ready;
  assign ifc.in_valid  = in_valid;
  assign ifc.in_data   = in_data[23:0];
  assign ifc.in_mask   = in_mask[2:0];
  assign ifc.in_last   = in_last;
  assign ifc.out_ready = out_ready;

  lane_reduce_accumulator #(.NUM_LANES(4), .W(8), .ACC_W(10), .CNT_W(3), .SIGNED(1'b0)) u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (ifa)
  );
  lane_reduce_accumulator #(.NUM_LANES(4), .W(8), .ACC_W(32), .CNT_W(16), .SIGNED(1'b1)) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (ifb)
  );
  lane_reduce_accumulator #(.NUM_LANES(3), .W(8), .ACC_W(11), .CNT_W(16), .SIGNED(1'b1)) u_dut_c (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .bus     (ifc)
  );

  typedef struct packed {
    logic [31:0] s0, s1, s2;
    logic [15:0] b0, b1, b2;
    logic        o0, o1, o2;
  } exp_t;

  exp_t   exp_q[$];
  longint m_acc[3];
  int     m_cnt[3];
  bit     m_ovf[3];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_flush();
    for (int k = 0; k < 3; k++) begin
      m_acc[k] = 0;
      m_cnt[k] = 0;
      m_ovf[k] = 1'b0;
    end
  endtask

  // Group arithmetic: each beat's lane sum is added to a running value, wrapped to ACC_W,
  // with overflow whenever the true result leaves the representable range.
  task automatic model_beat(input logic [31:0] d, input logic [3:0] m, input bit l);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      longint b, md, s, r, v;
      int     nl, aw, cmax;
      bit     sg;
      nl   = (k == 2) ? 3 : 4;
      aw   = (k == 0) ? 10 : ((k == 1) ? 32 : 11);
      cmax = (k == 0) ? 7 : 65535;
      sg   = (k != 0);
      b = 0;
      for (int i = 0; i < nl; i++) begin
        if (m[i]) begin
          v = longint'(d[i*8 +: 8]);
          if (sg && v >= 128) v = v - 256;
          b = b + v;
        end
      end
      md = longint'(1) << aw;
      s  = (sg && m_acc[k] >= md / 2) ? m_acc[k] - md : m_acc[k];
      r  = s + b;
      if (sg) begin
        if (r < -(md / 2) || r >= md / 2) m_ovf[k] = 1'b1;
      end else if (r >= md) begin
        m_ovf[k] = 1'b1;
      end
      m_acc[k] = ((r % md) + md) % md;
      if (m_cnt[k] < cmax) m_cnt[k]++;
    end
    if (l) begin
      e.s0 = 32'(m_acc[0]);
      e.s1 = 32'(m_acc[1]);
      e.s2 = 32'(m_acc[2]);
      e.b0 = 16'(m_cnt[0]);
      e.b1 = 16'(m_cnt[1]);
      e.b2 = 16'(m_cnt[2]);
      e.o0 = m_ovf[0];
      e.o1 = m_ovf[1];
      e.o2 = m_ovf[2];
      exp_q.push_back(e);
      model_flush();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the beat.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] m, input bit l);
    logic rdy;
    in_valid = 1'b1;
    in_data  = d;
    in_mask  = m;
    in_last  = l;
    for (int k = 0; k < 300; k++) begin
      @(negedge clock);
      rdy = ifa.in_ready;
      @(posedge clock);
      if (rdy) begin
        model_beat(d, m, l);
        #1;
        return;
      end
      #1;
    end
    n_vec++;
    n_miss++;
    $display("FAIL send_timeout: beat not accepted, in_ready=%0b", ifa.in_ready);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = $urandom;
    in_mask  = 4'($urandom);
    in_last  = 1'($urandom);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8080_8080;
      2:       return 32'h7F7F_7F7F;
      default: return $urandom;
    endcase
  endfunction

  task automatic send_group(input int n);
    for (int i = 0; i < n; i++) begin
      send_beat(rand_data(), 4'($urandom), i == n - 1);
    end
  endtask

  task automatic wait_pending();
    for (int k = 0; k < 50 && !ifa.out_valid; k++) begin
      @(posedge clock);
      #1;
    end
    chk("pending_valid", ifa.out_valid, 1);
  endtask

  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on every result handshake and checks hold behaviour under stall.
  initial begin
    exp_t        e;
    bit          stall_prev = 1'b0;
    logic [9:0]  prev_sum = '0;
    logic [2:0]  prev_beats = '0;
    logic        prev_ovf = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n || clear) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_valid", ifa.out_valid, 1);
          chk("hold_sum", ifa.out_sum, prev_sum);
          chk("hold_beats", ifa.out_beats, prev_beats);
          chk("hold_ovf", ifa.out_overflow, prev_ovf);
        end
        if (ifa.out_valid || ifb.out_valid || ifc.out_valid) begin
          chk("valid_b_vs_a", ifb.out_valid, ifa.out_valid);
          chk("valid_c_vs_a", ifc.out_valid, ifa.out_valid);
        end
        if (ifa.out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_result: sum_a=%0d with empty scoreboard", ifa.out_sum);
          end else begin
            e = exp_q.pop_front();
            chk("sum_a", ifa.out_sum, e.s0[9:0]);
            chk("beats_a", ifa.out_beats, e.b0[2:0]);
            chk("ovf_a", ifa.out_overflow, e.o0);
            chk("sum_b", ifb.out_sum, e.s1);
            chk("beats_b", ifb.out_beats, e.b1);
            chk("ovf_b", ifb.out_overflow, e.o1);
            chk("sum_c", ifc.out_sum, e.s2[10:0]);
            chk("beats_c", ifc.out_beats, e.b2);
            chk("ovf_c", ifc.out_overflow, e.o2);
          end
        end
        stall_prev = ifa.out_valid && !out_ready;
        prev_sum   = ifa.out_sum;
        prev_beats = ifa.out_beats;
        prev_ovf   = ifa.out_overflow;
      end
    end
  end

  initial begin
    model_flush();
    #2;
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_out_sum", ifa.out_sum, 0);
    chk("rst_out_beats", ifa.out_beats, 0);
    chk("rst_out_ovf", ifa.out_overflow, 0);
    chk("rst_in_ready", ifa.in_ready, 1);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(2);

    // Latency: lanes {1,2,3,4} accepted at edge t, result visible after edge t+3.
    send_beat(32'h0403_0201, 4'hF, 1'b1);
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clock);
      #1;
      chk($sformatf("latency_valid_t%0d", k), ifa.out_valid, (k == 3) ? 1 : 0);
    end
    chk("latency_sum", ifa.out_sum, 10);
    chk("latency_beats", ifa.out_beats, 1);
    idle(3);

    // Mask 0101 over {10,20,30,40}, then an all-masked last beat.
    send_beat(32'h281E_140A, 4'b0101, 1'b1);
    send_beat(32'h281E_140A, 4'b0000, 1'b1);
    idle(2);

    // Back-to-back groups.
    send_beat(32'h0101_0101, 4'hF, 1'b0);
    send_beat(32'h0202_0202, 4'hF, 1'b0);
    send_beat(32'h0303_0303, 4'hF, 1'b1);
    send_beat(32'h0505_0505, 4'hF, 1'b1);
    idle(6);

    // Unsigned wrap/overflow, then a clean group; signed all-ones.
    send_beat(32'hFFFF_FFFF, 4'hF, 1'b0);
    send_beat(32'hFFFF_FFFF, 4'hF, 1'b1);
    send_beat(32'h0000_0001, 4'hF, 1'b1);
    send_beat(32'hFFFF_FFFF, 4'hF, 1'b1);
    idle(2);

    // Beat-count saturation on the 3-bit counter.
    for (int i = 0; i < 10; i++) send_beat(32'h0000_0001, 4'h1, i == 9);
    idle(6);

    // Backpressure: results held, input stalls, nothing lost once released.
    rdy_mode = 2;
    fork
      begin
        send_group(1);
        send_group(3);
        send_group(2);
        send_group(1);
      end
      begin
        repeat (25) @(posedge clock);
        #2;
        chk("bp_in_ready_low", ifa.in_ready, 0);
        rdy_mode = 1;
      end
    join
    idle(1);
    rdy_mode = 0;
    idle(12);

    // Asynchronous reset with a result pending and a partial group in flight.
    rdy_mode = 2;
    send_beat(32'h0403_0201, 4'hF, 1'b1);
    send_beat(rand_data(), 4'hF, 1'b0);
    send_beat(rand_data(), 4'hF, 1'b0);
    in_valid = 1'b0;
    wait_pending();
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out_valid", ifa.out_valid, 0);
    chk("async_rst_in_ready", ifa.in_ready, 1);
    exp_q.delete();
    model_flush();
    rdy_mode = 0;
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    send_beat(32'h0403_0201, 4'hF, 1'b1);
    idle(6);

    // Synchronous clear with a stalled result and a partial group.
    rdy_mode = 2;
    send_beat(32'h0909_0909, 4'hF, 1'b1);
    send_beat(rand_data(), 4'hF, 1'b0);
    in_valid = 1'b0;
    wait_pending();
    clear = 1'b1;
    exp_q.delete();
    model_flush();
    @(posedge clock);
    #1;
    clear = 1'b0;
    chk("clear_out_valid", ifa.out_valid, 0);
    chk("clear_in_ready", ifa.in_ready, 1);
    rdy_mode = 0;
    idle(4);
    send_beat(32'h0000_0007, 4'hF, 1'b1);
    idle(6);

    // Randomised traffic with random backpressure and idle gaps carrying junk.
    rdy_mode = 1;
    for (int i = 0; i < 250; i++) begin
      send_beat(rand_data(), 4'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    send_beat(rand_data(), 4'($urandom), 1'b1);

    rdy_mode = 0;
    in_valid = 1'b0;
    for (int k = 0; k < 500 && exp_q.size() != 0; k++) @(posedge clock);
    chk("drain_empty", exp_q.size(), 0);
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
